ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DW, default 8: data width in bits.
REQ-002 Parameter AW, default 4: pointer width; FIFO depth is 2**AW = 16 entries.
REQ-003 Parameter AFULL_LVL, default 14: occupancy at or above which almost_full is asserted.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Port wr_en, input, 1: push request.
REQ-007 Port wr_data, input, DW: push data.
REQ-008 Port rd_en, input, 1: pop request.
REQ-009 Port rd_data, output, DW: pop data, valid only while rd_valid=1.
REQ-010 Port rd_valid, output, 1: rd_data is valid this cycle.
REQ-011 Ports full, empty, almost_full, output, 1 each: status flags.
REQ-012 Port count, output, AW+1: current occupancy, 0..16.
REQ-013 Ports overflow and underflow, output, 1 each: sticky error flags.
REQ-014 Ports ram_addr1 (8), ram_din1 (DW) and ram_we1 (1), output: RAM port 1, used as the write port.
REQ-015 Ports ram_addr2 (8) and ram_we2 (1), output: RAM port 2, used as the read port.
REQ-016 Port ram_dout2, input, DW: registered read data from RAM port 2.

Function
REQ-017 The block shall control the team's 16x8 dual-port RAM as a synchronous FIFO, with port 1 for writes only and port 2 for reads only.
REQ-018 A push shall be accepted when wr_en=1 and full=0; a pop shall be accepted when rd_en=1 and empty=0.
REQ-019 ram_we1 shall equal the push-accepted condition (combinational), ram_din1 shall equal wr_data, and ram_addr1 shall equal {zero-pad, wr_ptr}.
REQ-020 ram_we2 shall be tied to 0 and ram_addr2 shall equal {zero-pad, rd_ptr}.
REQ-021 Read latency shall be 1 cycle: a pop accepted in cycle N shall give rd_valid=1 in cycle N+1, with rd_data = ram_dout2 (combinational pass-through).
REQ-022 rd_valid shall be registered and shall be 0 in any cycle that does not follow an accepted pop.
REQ-023 wr_ptr and rd_ptr shall each be AW bits, increment by 1 per accepted operation, and wrap from 15 to 0.
REQ-024 count shall update as follows: +1 on a push only, -1 on a pop only, unchanged when both or neither are accepted.
REQ-025 Flags shall be decoded from count as follows: full = (count==16), empty = (count==0), almost_full = (count>=AFULL_LVL).
REQ-026 When full, a push shall be rejected even if a pop is accepted in the same cycle; the pop shall proceed.
REQ-027 When empty, a pop shall be rejected even if a push is accepted in the same cycle; the push shall proceed.
REQ-028 Because of REQ-026 and REQ-027, port 1 and port 2 shall never access the same address with a write and a valid read in the same cycle.
REQ-029 overflow shall set on wr_en=1 while full=1, and underflow shall set on rd_en=1 while empty=1; both shall hold until reset.
REQ-030 Rejected operations shall not change the pointers, count or RAM contents.

Reset
REQ-031 While rst_n=0 at a rising edge, the following shall be cleared to 0: wr_ptr, rd_ptr, count, rd_valid, overflow and underflow.
REQ-032 After reset, empty=1, full=0 and almost_full=0.
REQ-033 ram_we1 shall be forced to 0 while rst_n=0.
REQ-034 A pop accepted in the cycle reset is asserted shall produce no rd_valid.
REQ-035 RAM contents are not cleared by reset, and stale RAM data shall never be presented with rd_valid=1.

Structure
REQ-036 Package fifo_pkg shall hold DW, AW, DEPTH and RAM_AW=8 as constants.
REQ-037 The block shall be a single module with no sub-module; the RAM shall be instantiated beside it at the integration level.

Verification
REQ-038 Scenario: reset, then push 0x11, 0x22, 0x33, then pop three times -> rd_valid pulses one cycle after each pop, with rd_data 0x11, 0x22, 0x33 in order; empty=1 at the end.
REQ-039 Scenario: push 16 values -> full=1, count=16 and almost_full asserted from count=14; a 17th push is rejected (ram_we1=0) and sets overflow=1.
REQ-040 Scenario: with the FIFO full, assert wr_en and rd_en together -> the pop is accepted, the push is rejected, and count becomes 15.
REQ-041 Scenario: with the FIFO empty, assert wr_en and rd_en together -> the push is accepted, there is no rd_valid, count becomes 1, and underflow=1.
REQ-042 Scenario: run 40 alternating push/pop pairs -> pointers wrap past 15 to 0 and the data order is preserved.
REQ-043 Scenario: with 5 entries stored and a pop in flight, assert rst_n=0 -> the next cycle shows rd_valid=0, count=0 and empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants for the RAM-backed FIFO controller
package fifo_pkg;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 2 ** AW;
  localparam int RAM_AW = 8;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - synchronous FIFO controller driving an external dual-port RAM
module ram_fifo_ctrl #(
  parameter int DW        = fifo_pkg::DW,
  parameter int AW        = fifo_pkg::AW,
  parameter int AFULL_LVL = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DW-1:0]             wr_data,
  input  logic                      rd_en,
  output logic [DW-1:0]             rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [AW:0]               count,
  output logic                      overflow,
  output logic                      underflow,
  output logic [fifo_pkg::RAM_AW-1:0] ram_addr1,
  output logic [DW-1:0]             ram_din1,
  output logic                      ram_we1,
  output logic [fifo_pkg::RAM_AW-1:0] ram_addr2,
  output logic                      ram_we2,
  input  logic [DW-1:0]             ram_dout2
);
  localparam logic [AW:0] FULL_CNT  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Full blocks pushes and empty blocks pops regardless of the other side,
  // so a write and a valid read never target the same RAM word in one cycle.
  assign push = wr_en & ~full & rst_n;
  assign pop  = rd_en & ~empty;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_CNT);

  assign ram_we1   = push;
  assign ram_din1  = wr_data;
  assign ram_addr1 = fifo_pkg::RAM_AW'(wr_ptr);
  assign ram_we2   = 1'b0;
  assign ram_addr2 = fifo_pkg::RAM_AW'(rd_ptr);
  assign rd_data   = ram_dout2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl with a behavioural RAM
module tb_ram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic [7:0] ram_addr1;
  logic [7:0] ram_din1;
  logic       ram_we1;
  logic [7:0] ram_addr2;
  logic       ram_we2;
  logic [7:0] ram_dout2;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;
  int wp = 0;
  int rp = 0;

  ram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
    .ram_addr1(ram_addr1), .ram_din1(ram_din1), .ram_we1(ram_we1),
    .ram_addr2(ram_addr2), .ram_we2(ram_we2), .ram_dout2(ram_dout2)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model standing in for the integration-level RAM
  always @(posedge clk) begin
    if (ram_we1) mem[ram_addr1] <= ram_din1;
    ram_dout2 <= mem[ram_addr2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic push_chk(input logic [7:0] d);
    check("addr1_wptr", 32'(ram_addr1), 32'(wp));
    cyc(1'b1, d, 1'b0);
    wp = (wp + 1) % 16;
  endtask

  task automatic pop_chk(input logic [7:0] d);
    check("addr2_rptr", 32'(ram_addr2), 32'(rp));
    cyc(1'b0, 8'h00, 1'b1);
    rp = (rp + 1) % 16;
    check("pop_valid", 32'(rd_valid), 32'd1);
    check("pop_data", 32'(rd_data), 32'(d));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    ram_dout2 = 8'hEE;
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
    #1;
    check("we1_in_reset", 32'(ram_we1), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("we2_tied", 32'(ram_we2), 32'd0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;

    // three pushes then three pops
    push_chk(8'h11); push_chk(8'h22); push_chk(8'h33);
    check("s1_count3", 32'(count), 32'd3);
    pop_chk(8'h11); pop_chk(8'h22); pop_chk(8'h33);
    check("s1_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    check("s1_idle_no_valid", 32'(rd_valid), 32'd0);

    // fill to full, watch almost_full threshold
    for (int i = 0; i < 16; i++) begin
      push_chk(8'(8'hA0 + i));
      check("s2_afull", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
    end
    check("s2_full", 32'(full), 32'd1);
    check("s2_count16", 32'(count), 32'd16);
    check("s2_no_ovf_yet", 32'(overflow), 32'd0);
    wr_en = 1'b1; wr_data = 8'h5A; #1;
    check("s2_we1_reject", 32'(ram_we1), 32'd0);
    @(posedge clk); #1; wr_en = 1'b0;
    check("s2_ovf", 32'(overflow), 32'd1);
    check("s2_count_hold", 32'(count), 32'd16);

    // simultaneous push and pop while full
    check("addr2_rptr", 32'(ram_addr2), 32'(rp));
    cyc(1'b1, 8'h55, 1'b1);
    rp = (rp + 1) % 16;
    check("s3_valid", 32'(rd_valid), 32'd1);
    check("s3_data", 32'(rd_data), 32'hA0);
    check("s3_count15", 32'(count), 32'd15);
    check("s3_not_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) pop_chk(8'(8'hA0 + i));
    check("s3_empty", 32'(empty), 32'd1);

    // simultaneous push and pop while empty
    check("s4_no_unf_yet", 32'(underflow), 32'd0);
    check("addr1_wptr", 32'(ram_addr1), 32'(wp));
    cyc(1'b1, 8'h77, 1'b1);
    wp = (wp + 1) % 16;
    check("s4_no_valid", 32'(rd_valid), 32'd0);
    check("s4_count1", 32'(count), 32'd1);
    check("s4_unf", 32'(underflow), 32'd1);
    pop_chk(8'h77);

    // alternating pairs wrap both pointers several times
    for (int i = 0; i < 40; i++) begin
      push_chk(8'(i * 7 + 3));
      pop_chk(8'(i * 7 + 3));
    end
    check("s5_empty", 32'(empty), 32'd1);
    check("s5_wp", 32'(ram_addr1), 32'(wp));

    // reset with five stored and a pop in flight
    for (int i = 0; i < 5; i++) push_chk(8'(8'hC0 + i));
    check("s6_count5", 32'(count), 32'd5);
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    check("s6_rd_valid", 32'(rd_valid), 32'd0);
    check("s6_count0", 32'(count), 32'd0);
    check("s6_empty", 32'(empty), 32'd1);
    check("s6_ovf_clr", 32'(overflow), 32'd0);
    check("s6_unf_clr", 32'(underflow), 32'd0);
    check("s6_addr1", 32'(ram_addr1), 32'd0);
    check("s6_addr2", 32'(ram_addr2), 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    check("s6_post_no_valid", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
